// File: rtl/fib_arbiter_pkg.sv
// Shared types and helpers for the Fibonacci core arbiter.
package fib_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CLR,
        WAIT_DONE,
        RESPOND
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first pending request at or after ptr_i wins.
module rr_arbiter
    import fib_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand [NUM_REQ];

    // cand[k] is the requester examined k places after the pointer, wrapped.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum       = {1'b0, ptr_i} + (IDX_W+1)'(gi);
        assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                        : sum[IDX_W-1:0];
    end

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        // Scan farthest first so the nearest pending requester overwrites the rest.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[cand[k]]) begin
                grant_o          = '0;
                grant_o[cand[k]] = 1'b1;
                idx_o            = cand[k];
                any_o            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_arbiter.sv
// Shares one Fibonacci core among NUM_REQ requesters with round-robin grants.
// Define FIB_ARB_TIMEOUT_EN to add a watchdog that answers with resp_timeout after TIMEOUT_CYC.
module fib_arbiter
    import fib_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 16,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [OUTPUT_WIDTH-1:0]        resp_result,
    output logic                           resp_overflow,
    output logic                           resp_timeout,
    output logic                           core_go,
    output logic [INPUT_WIDTH-1:0]         core_n,
    input  logic [OUTPUT_WIDTH-1:0]        core_result,
    input  logic                           core_overflow,
    input  logic                           core_done
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        win_q, win_d;
    logic [INPUT_WIDTH-1:0]  n_q, n_d;
    logic [OUTPUT_WIDTH-1:0] result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    tmo_q, tmo_d;

    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    timed_out;
    logic [INPUT_WIDTH-1:0]  req_n_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_n
        assign req_n_arr[gi] = req_n[gi*INPUT_WIDTH +: INPUT_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

`ifdef FIB_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_width(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT_CLR || state_q == WAIT_DONE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timed_out          = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        n_d      = n_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = ISSUE;
                    win_d   = grant_idx;
                    n_d     = req_n_arr[grant_idx];
                    ptr_d   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            ISSUE: state_d = WAIT_CLR;
            // A done left high by the previous job must drop before we trust it again.
            WAIT_CLR: begin
                if (timed_out) begin
                    state_d  = RESPOND;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    tmo_d    = 1'b1;
                end else if (!core_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_done) begin
                    state_d  = RESPOND;
                    result_d = core_result;
                    ovf_d    = core_overflow;
                    tmo_d    = 1'b0;
                end else if (timed_out) begin
                    state_d  = RESPOND;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    tmo_d    = 1'b1;
                end
            end
            RESPOND: begin
                if (resp_ready[win_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            n_q      <= n_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    // The grant is combinational, so suppress it while reset holds the FSM.
    assign req_ready     = (state_q == IDLE && !rst) ? grant : '0;
    assign core_go       = (state_q == ISSUE);
    assign core_n        = n_q;
    assign resp_valid    = (state_q == RESPOND) ? (NUM_REQ'(1) << win_q) : '0;
    assign resp_result   = (state_q == RESPOND) ? result_q : '0;
    assign resp_overflow = (state_q == RESPOND) && ovf_q;
    assign resp_timeout  = (state_q == RESPOND) && tmo_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// Bench for fib_arbiter: behavioural core model, grant/response scoreboard, vector table.
`timescale 1ns/1ps
module tb_fib_arbiter;

    localparam int NR  = 4;
    localparam int IW  = 6;
    localparam int OW  = 16;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*IW-1:0] req_n = '0;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  resp_valid;
    logic [NR-1:0]  resp_ready = '1;
    logic [OW-1:0]  resp_result;
    logic           resp_overflow;
    logic           resp_timeout;
    logic           core_go;
    logic [IW-1:0]  core_n;
    logic [OW-1:0]  core_result = '0;
    logic           core_overflow = 1'b0;
    logic           core_done = 1'b0;

    always #5 clk = ~clk;

    fib_arbiter #(
        .NUM_REQ      (NR),
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (OW),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_n         (req_n),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_overflow (resp_overflow),
        .resp_timeout  (resp_timeout),
        .core_go       (core_go),
        .core_n        (core_n),
        .core_result   (core_result),
        .core_overflow (core_overflow),
        .core_done     (core_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Core numbering: F(0)=F(1)=0, F(2)=1, i.e. the classic sequence shifted by one.
    function automatic longint unsigned fib(input int n);
        longint unsigned a = 0, b = 1, t;
        if (n == 0) return 0;
        for (int i = 1; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Core model: drops done two cycles after go, raises it with the result a few cycles later.
    logic          core_stall = 1'b0;
    logic          core_busy  = 1'b0;
    int            core_cnt   = 0;
    logic [IW-1:0] core_n_lat = '0;

    always @(posedge clk) begin
        if (core_go) begin
            core_busy  <= 1'b1;
            core_cnt   <= 0;
            core_n_lat <= core_n;
        end else if (core_busy) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == 1) core_done <= 1'b0;
            if (core_cnt >= 4 && !core_stall) begin
                core_done     <= 1'b1;
                core_result   <= OW'(fib(int'(core_n_lat)));
                core_overflow <= (fib(int'(core_n_lat)) >= (64'd1 << OW));
                core_busy     <= 1'b0;
            end
        end
    end

    typedef struct {
        int          idx;
        int          n;
        logic [OW-1:0] res;
        logic        ovf;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   cyc = 0, grant_cyc = -10, go_cyc = 0, rise_cyc = 0;
    logic in_flight = 1'b0;
    logic done_p1 = 1'b0, done_p2 = 1'b0, go_prev = 1'b0;
    logic [NR-1:0] vprev = '0;
    exp_t mon_e, mon_p;
    int   mon_w;
    logic timeout_build;

    initial begin
`ifdef FIB_ARB_TIMEOUT_EN
        timeout_build = 1'b1;
`else
        timeout_build = 1'b0;
`endif
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (resp_valid == '0)
                chk("idle_resp_zero", {resp_result, resp_overflow, resp_timeout}, 0);
            if (req_ready != '0) begin
                chk("grant_onehot", $countones(req_ready), 1);
                chk("grant_while_busy", in_flight, 0);
                mon_w   = oh_idx(req_ready);
                mon_e.idx = mon_w;
                mon_e.n   = int'(req_n[mon_w*IW +: IW]);
                if (core_stall && timeout_build) begin
                    mon_e.res = '0;
                    mon_e.ovf = 1'b0;
                    mon_e.tmo = 1'b1;
                end else begin
                    mon_e.res = OW'(fib(mon_e.n));
                    mon_e.ovf = (fib(mon_e.n) >= (64'd1 << OW));
                    mon_e.tmo = 1'b0;
                end
                sb.push_back(mon_e);
                grant_log.push_back(mon_w);
                in_flight = 1'b1;
                grant_cyc = cyc;
            end
            if (core_go) begin
                go_cyc = cyc;
                chk("go_latency", cyc - grant_cyc, 1);
                chk("go_single_pulse", go_prev, 0);
                chk("go_job_pending", sb.size(), 1);
                if (sb.size() > 0) chk("core_n", core_n, sb[0].n);
            end
            if (resp_valid != '0 && vprev == '0) begin
                rise_cyc = cyc;
                if (sb.size() > 0 && !sb[0].tmo)
                    chk("done_to_valid", {done_p2, done_p1}, 2'b01);
            end
            if ((resp_valid & resp_ready) != '0) begin
                chk("resp_onehot", $countones(resp_valid), 1);
                chk("resp_has_job", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_p = sb.pop_front();
                    chk("resp_idx", oh_idx(resp_valid), mon_p.idx);
                    chk("resp_result", resp_result, mon_p.res);
                    chk("resp_overflow", resp_overflow, mon_p.ovf);
                    chk("resp_timeout", resp_timeout, mon_p.tmo);
                    $display("[TB] resp req%0d n=%0d result=%0d ovf=%0b tmo=%0b",
                             mon_p.idx, mon_p.n, resp_result, resp_overflow, resp_timeout);
                end
                in_flight = 1'b0;
            end
        end
        done_p2 = done_p1;
        done_p1 = core_done;
        go_prev = core_go;
        vprev   = resp_valid;
    end

    task automatic do_single(input int idx, input int n, input int res, input int ovf, input int tmo);
        int k;
        @(posedge clk); #1;
        req_n[idx*IW +: IW] = IW'(n);
        req_valid[idx]      = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[idx] && k < 50);
        chk("grant_seen", req_ready[idx], 1);
        @(posedge clk); #1 req_valid[idx] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!resp_valid[idx] && k < 200);
        chk("resp_seen", resp_valid[idx], 1);
        chk("tbl_result", resp_result, res);
        chk("tbl_overflow", resp_overflow, ovf);
        chk("tbl_timeout", resp_timeout, tmo);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || resp_valid != '0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drained", sb.size(), 0);
    endtask

    task automatic run_group(input logic [NR-1:0] mask, input logic drop, input int ngrants);
        int got = 0, k = 0;
        logic [NR-1:0] g;
        grant_log.delete();
        @(posedge clk); #1 req_valid = mask;
        while (got < ngrants && k < 400) begin
            @(negedge clk);
            k++;
            g = req_ready;
            if (g != '0) got++;
            @(posedge clk); #1;
            if (drop) req_valid = req_valid & ~g;
        end
        req_valid = '0;
        chk("group_grants", got, ngrants);
        wait_drain();
    endtask

    typedef struct { int idx; int n; int res; int ovf; } vec_t;
    vec_t vecs[8];

    initial begin
        int exp_all[4];
        int exp_fair[4];
        int k;
        exp_all  = '{0, 1, 2, 3};
        exp_fair = '{0, 2, 0, 2};
        // Table ends on requester 3 so the pointer is back at 0 for the group tests.
        vecs[0] = '{0, 10, 34,    0};
        vecs[1] = '{1, 0,  0,     0};
        vecs[2] = '{2, 1,  0,     0};
        vecs[3] = '{2, 2,  1,     0};
        vecs[4] = '{3, 25, 46368, 0};
        vecs[5] = '{0, 26, 9489,  1};
        vecs[6] = '{1, 14, 233,   0};
        vecs[7] = '{3, 15, 377,   0};

        // Reset: grants suppressed even with requests pending, all outputs 0.
        req_valid = 4'b0101;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_core_go", core_go, 0);
        chk("rst_core_n", core_n, 0);
        chk("rst_resp_data", {resp_result, resp_overflow, resp_timeout}, 0);
        @(posedge clk); #1 req_valid = '0; rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_single(vecs[i].idx, vecs[i].n, vecs[i].res, vecs[i].ovf, 0);
            $display("[TB] vec %0d req%0d n=%0d expect %0d", i, vecs[i].idx, vecs[i].n, vecs[i].res);
        end

        // All four at once, n=3..6.
        req_n = {6'd6, 6'd5, 6'd4, 6'd3};
        run_group(4'b1111, 1'b1, 4);
        chk("all_order_len", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) chk("all_order", grant_log[i], exp_all[i]);

        // Fairness: req0 and req2 never withdraw.
        req_n = {6'd0, 6'd12, 6'd0, 6'd8};
        run_group(4'b0101, 1'b0, 4);
        chk("fair_order_len", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) chk("fair_order", grant_log[i], exp_fair[i]);

        // Backpressure on requester 1; other readies high and ignored.
        resp_ready = 4'b1101;
        @(posedge clk); #1 req_n[1*IW +: IW] = 6'd7; req_valid[1] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[1] && k < 50);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!resp_valid[1] && k < 200);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 4'b0010);
            chk("bp_result", resp_result, 8);
            chk("bp_no_go", core_go, 0);
        end
        // Response handshake and a new request in the same cycle.
        @(posedge clk); #1 resp_ready = '1; req_n[3*IW +: IW] = 6'd4; req_valid[3] = 1'b1;
        @(negedge clk);
        chk("hs_cycle_no_grant", req_ready, 0);
        chk("hs_cycle_valid", resp_valid, 4'b0010);
        @(negedge clk);
        chk("grant_after_hs", req_ready, 4'b1000);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        wait_drain();

        // Reset while waiting on a stalled core: job dropped, no response.
        core_stall = 1'b1;
        @(posedge clk); #1 req_n[0 +: IW] = 6'd10; req_valid[0] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[0] && k < 50);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!core_go && k < 20);
        repeat (6) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", {req_ready, resp_valid, core_go, core_n}, 0);
        chk("midrst_data", {resp_result, resp_overflow, resp_timeout}, 0);
        @(posedge clk); #1 rst = 1'b0; sb.delete(); in_flight = 1'b0; core_stall = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_resp", resp_valid, 0);
        end
        do_single(2, 9, 21, 0, 0);

`ifdef FIB_ARB_TIMEOUT_EN
        core_stall = 1'b1;
        do_single(1, 5, 0, 0, 1);
        chk("timeout_latency", rise_cyc - go_cyc, TMO + 1);
        core_stall = 1'b0;
        do_single(3, 6, 5, 0, 0);
`endif

        wait_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
        $fatal(1);
    end

endmodule
